clock_display_scan: RTL and testbench

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

---
 rtl/clock_display_scan.sv | 169 ++++++++++++++++
 tb/tb_clock_display_scan.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed 7-segment scanner for time/date display
module clock_display_scan #(
    parameter int SCAN_DIV  = 32,
    parameter int BLINK_BIT = 13
) (
    input  logic       clk_32_768K,
    input  logic       Rst_n,
    input  logic [5:0] Sec_Time,
    input  logic [5:0] Min_Time,
    input  logic [4:0] Hr_Time,
    input  logic [5:0] Day_Date,
    input  logic [3:0] Mon_Date,
    input  logic [6:0] Year_Date,
    input  logic [1:0] Blink,
    input  logic       Display,
    output logic [6:0] Seg,
    output logic [5:0] Dig_En,
    output logic       Dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    // Everything a frame needs, frozen at frame start so a frame never mixes old and new data
    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hr;
        logic [5:0] day;
        logic [3:0] mon;
        logic [6:0] year;
        logic       disp;
        logic [1:0] blink;
        logic       phase;
    } snap_t;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    slot_q, slot_d;
    logic          tick_dly_q, tick_dly_d;
    logic [13:0]   flash_q, flash_d;
    snap_t         snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    dig_en_q, dig_en_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          frame_start;
    logic [1:0]    pair;
    logic [6:0]    field_val;
    logic [7:0]    bcd;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_next;
    logic [5:0]    dig_en_next;
    logic          dp_next;

    // Tens/units by repeated subtraction; exact for 0..99, larger values are shown as dashes anyway
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick        = (presc_q == PRESC_MAX);
    assign frame_start = tick && (slot_q == 3'd5);

    // Timing state: prescaler, slot sequencer, flash counter and frame snapshot
    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        tick_dly_d = tick;
        flash_d    = flash_q + 14'd1;
        slot_d     = slot_q;
        snap_d     = snap_q;
        if (tick) begin
            slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end
        if (frame_start) begin
            snap_d.sec   = Sec_Time;
            snap_d.min   = Min_Time;
            snap_d.hr    = Hr_Time;
            snap_d.day   = Day_Date;
            snap_d.mon   = Mon_Date;
            snap_d.year  = Year_Date;
            snap_d.disp  = Display;
            snap_d.blink = Blink;
            snap_d.phase = flash_q[BLINK_BIT];
        end
    end

    // Decode the current slot from the snapshot; outputs load only on the cycle after a tick
    always_comb begin
        pair = slot_q[2:1];
        case (pair)
            2'd0:    field_val = snap_q.disp ? {1'b0, snap_q.day}  : {1'b0, snap_q.sec};
            2'd1:    field_val = snap_q.disp ? {3'b0, snap_q.mon}  : {1'b0, snap_q.min};
            default: field_val = snap_q.disp ? snap_q.year         : {2'b0, snap_q.hr};
        endcase
        bcd   = bin_to_bcd(field_val);
        digit = slot_q[0] ? bcd[7:4] : bcd[3:0];
        if (field_val > 7'd99) begin
            seg_next = 7'h3F;
        end else begin
            seg_next = seg_code(digit);
        end
        // Blink code 01/10/11 maps to pair 0/1/2 (right/middle/left)
        blank       = snap_q.phase && (snap_q.blink != 2'b00) && ((snap_q.blink - 2'd1) == pair);
        dig_en_next = blank ? 6'b111111 : ~(6'b000001 << slot_q);
        dp_next     = !((slot_q == 3'd2) || (slot_q == 3'd4));

        seg_d    = tick_dly_q ? seg_next    : seg_q;
        dig_en_d = tick_dly_q ? dig_en_next : dig_en_q;
        dp_d     = tick_dly_q ? dp_next     : dp_q;
    end

    // State register; reset parks on slot 5 so the first tick starts a frame
    always_ff @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) begin
            presc_q    <= '0;
            slot_q     <= 3'd5;
            tick_dly_q <= 1'b0;
            flash_q    <= 14'd0;
            snap_q     <= '0;
            seg_q      <= 7'h7F;
            dig_en_q   <= 6'b111111;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            slot_q     <= slot_d;
            tick_dly_q <= tick_dly_d;
            flash_q    <= flash_d;
            snap_q     <= snap_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
            dp_q       <= dp_d;
        end
    end

    assign Seg    = seg_q;
    assign Dig_En = dig_en_q;
    assign Dp     = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - scoreboard bench for clock_display_scan
module tb_clock_display_scan;

    logic       clk_32_768K = 1'b0;
    logic       Rst_n;
    logic [5:0] sc, mn, dy;
    logic [4:0] hr;
    logic [3:0] mo;
    logic [6:0] yr;
    logic [1:0] bl;
    logic       disp;
    logic [6:0] Seg;
    logic [5:0] Dig_En;
    logic       Dp;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    logic [16:0] sb[$];
    logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    clock_display_scan dut (
        .clk_32_768K(clk_32_768K), .Rst_n(Rst_n),
        .Sec_Time(sc), .Min_Time(mn), .Hr_Time(hr),
        .Day_Date(dy), .Mon_Date(mo), .Year_Date(yr),
        .Blink(bl), .Display(disp),
        .Seg(Seg), .Dig_En(Dig_En), .Dp(Dp)
    );

    always #5 clk_32_768K = ~clk_32_768K;

    // Rising edges seen since the last reset release
    always @(posedge clk_32_768K or negedge Rst_n) begin
        if (!Rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [13:0] model(int s, bit ph);
        int v;
        int pair;
        logic [6:0] sg;
        logic [5:0] de;
        bit blank;
        pair = s / 2;
        if (!disp) v = (pair == 0) ? int'(sc) : (pair == 1) ? int'(mn) : int'(hr);
        else       v = (pair == 0) ? int'(dy) : (pair == 1) ? int'(mo) : int'(yr);
        if (v > 99) sg = 7'h3F;
        else        sg = segtab[(s % 2 == 1) ? v / 10 : v % 10];
        case (bl)
            2'b01:   blank = (pair == 0);
            2'b10:   blank = (pair == 1);
            2'b11:   blank = (pair == 2);
            default: blank = 1'b0;
        endcase
        blank = blank && ph;
        de = blank ? 6'h3F : (6'h3F ^ (6'b000001 << s));
        return {sg, de, ((s == 2) || (s == 4)) ? 1'b0 : 1'b1};
    endfunction

    function automatic int next_fs();
        int fs;
        fs = 32;
        while (fs <= cyc) fs += 192;
        return fs;
    endfunction

    function automatic bit phase_of(int fs);
        return bit'(((fs - 1) >> 13) & 1);
    endfunction

    task automatic push_frame();
        bit ph;
        ph = phase_of(next_fs());
        for (int s = 0; s < 6; s++) sb.push_back({3'(s), model(s, ph)});
    endtask

    task automatic next_update(output int slot);
        int t;
        int guard;
        t = 33;
        while (t <= cyc) t += 32;
        guard = 0;
        while (cyc != t && guard < 200) begin
            @(posedge clk_32_768K);
            #1;
            guard++;
        end
        if (cyc != t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL update_timeout cyc=%0d required=%0d", cyc, t);
        end
        slot = ((t - 33) / 32) % 6;
    endtask

    task automatic wait_cyc(int target);
        int guard;
        guard = 0;
        while (cyc != target && guard < 200) begin
            @(posedge clk_32_768K);
            #1;
            guard++;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        disp = 1'b0; bl = 2'b00;
        hr = 5'd12; mn = 6'd34; sc = 6'd56;
        yr = 7'd0; mo = 4'd0; dy = 6'd0;
        repeat (3) @(posedge clk_32_768K);
        #1;
        n_cmp++;
        if ({Seg, Dig_En, Dp} !== {7'h7F, 6'h3F, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state got %h required %h", {Seg, Dig_En, Dp}, {7'h7F, 6'h3F, 1'b1});
        end
        @(negedge clk_32_768K);
        Rst_n = 1'b1;
        #1;
        push_frame();
        wait_cyc(32);
        n_cmp++;
        if ({Seg, Dig_En, Dp} !== {7'h7F, 6'h3F, 1'b1}) begin
            n_bad++;
            $display("FAIL pre_first_slot cyc=%0d got %h required %h", cyc, {Seg, Dig_En, Dp}, {7'h7F, 6'h3F, 1'b1});
        end
    endtask

    task automatic test_time_page();
        int s;
        logic [16:0] e;
        repeat (6) begin
            next_update(s);
            e = sb.pop_front();
            n_cmp++;
            if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                n_bad++;
                $display("FAIL time_page slot=%0d got %h required %h", s, {Seg, Dig_En, Dp}, e[13:0]);
            end
        end
    endtask

    task automatic test_date_page();
        int s;
        logic [16:0] e;
        for (int k = 0; k < 2; k++) begin
            disp = 1'b1; yr = (k == 0) ? 7'd7 : 7'd120; mo = 4'd9; dy = 6'd1;
            push_frame();
            repeat (6) begin
                next_update(s);
                e = sb.pop_front();
                n_cmp++;
                if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                    n_bad++;
                    $display("FAIL date_page yr=%0d slot=%0d got %h required %h", yr, s, {Seg, Dig_En, Dp}, e[13:0]);
                end
            end
        end
    endtask

    task automatic test_midframe_change();
        int s;
        logic [16:0] e;
        disp = 1'b0; hr = 5'd12; mn = 6'd34; sc = 6'd56;
        push_frame();
        repeat (6) begin
            next_update(s);
            if (s == 3) sc = 6'd57;
            e = sb.pop_front();
            n_cmp++;
            if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                n_bad++;
                $display("FAIL midframe_hold slot=%0d got %h required %h", s, {Seg, Dig_En, Dp}, e[13:0]);
            end
        end
        push_frame();
        repeat (6) begin
            next_update(s);
            e = sb.pop_front();
            n_cmp++;
            if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                n_bad++;
                $display("FAIL midframe_next slot=%0d got %h required %h", s, {Seg, Dig_En, Dp}, e[13:0]);
            end
        end
    endtask

    task automatic skip_to_phase(bit p);
        int s;
        int frames;
        frames = 0;
        while (phase_of(next_fs()) != p && frames < 100) begin
            s = -1;
            while (s != 5) next_update(s);
            frames++;
        end
    endtask

    task automatic test_blink();
        int s;
        logic [16:0] e;
        logic [1:0] pat [0:4] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b00};
        for (int k = 0; k < 5; k++) begin
            skip_to_phase(k == 0 ? 1'b0 : 1'b1);
            disp = 1'b0; hr = 5'd9; mn = 6'd45; sc = 6'd3;
            bl = pat[k];
            push_frame();
            repeat (6) begin
                next_update(s);
                e = sb.pop_front();
                n_cmp++;
                if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                    n_bad++;
                    $display("FAIL blink bl=%b slot=%0d got %h required %h", bl, s, {Seg, Dig_En, Dp}, e[13:0]);
                end
            end
        end
        bl = 2'b00;
    endtask

    task automatic test_min_sweep();
        int s;
        logic [16:0] e;
        disp = 1'b0; bl = 2'b00; hr = 5'd23; sc = 6'd59;
        for (int v = 0; v < 100; v++) begin
            mn = 6'(v);
            push_frame();
            repeat (6) begin
                next_update(s);
                e = sb.pop_front();
                if (s == 2 || s == 3) begin
                    n_cmp++;
                    if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                        n_bad++;
                        $display("FAIL min_sweep min=%0d slot=%0d got %h required %h", v, s, {Seg, Dig_En, Dp}, e[13:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int s;
        logic [16:0] e;
        disp = 1'b0; hr = 5'd12; mn = 6'd34; sc = 6'd56;
        s = -1;
        while (s != 4) next_update(s);
        repeat (5) @(posedge clk_32_768K);
        #3;
        Rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({Seg, Dig_En, Dp} !== {7'h7F, 6'h3F, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset got %h required %h", {Seg, Dig_En, Dp}, {7'h7F, 6'h3F, 1'b1});
        end
        repeat (2) @(negedge clk_32_768K);
        Rst_n = 1'b1;
        #1;
        push_frame();
        wait_cyc(32);
        n_cmp++;
        if ({Seg, Dig_En, Dp} !== {7'h7F, 6'h3F, 1'b1}) begin
            n_bad++;
            $display("FAIL restart_latency cyc=%0d got %h required %h", cyc, {Seg, Dig_En, Dp}, {7'h7F, 6'h3F, 1'b1});
        end
        repeat (6) begin
            next_update(s);
            e = sb.pop_front();
            n_cmp++;
            if ({Seg, Dig_En, Dp} !== e[13:0] || s != int'(e[16:14])) begin
                n_bad++;
                $display("FAIL restart_frame slot=%0d got %h required %h", s, {Seg, Dig_En, Dp}, e[13:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_time_page();
        test_date_page();
        test_midframe_change();
        test_blink();
        test_min_sweep();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
